// File: rtl/ahb_bus_arb_if_pkg.sv
// ahb_bus_arb_if_pkg: shared encodings and kseg remap helper for the multi-channel AHB bridge.
package ahb_bus_arb_if_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} bus_st_e;
  typedef enum logic [1:0] {CH_IDLE, CH_WAIT, CH_HOLD} ch_st_e;
  localparam logic RstEnable = 1'b1;
  localparam logic Stop = 1'b1;
  localparam logic NoStop = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic [1:0] KSEG_TAG = 2'b10;
  // kseg0/kseg1 (0x8..0xB) fold onto physical 0x0/0x1
  function automatic logic [3:0] kseg_strip(input logic [3:0] hi);
    return hi[3:2] == KSEG_TAG ? {3'b000, hi[0]} : hi;
  endfunction
endpackage

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: picks one requester, lowest index (fixed) or first after ptr_i (round-robin).
module ahb_rr_arbiter #(
  parameter int N_CH = 2,
  parameter int ARB_RR = 1,
  parameter int IW = 1
)(
  input  logic [N_CH-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  logic [IW-1:0] j;
  // scan from lowest to highest priority so the last hit wins
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = N_CH; k >= 1; k--) begin
      j = IW'(ARB_RR != 0 ? (int'(ptr_i) + k) % N_CH : k - 1);
      idx_o = req_i[j] ? j : idx_o;
    end
  end
  assign any_o = |req_i;
  assign gnt_o = any_o ? N_CH'(1) << idx_o : '0;
endmodule

// File: rtl/ahb_bus_arb_if.sv
// ahb_bus_arb_if: arbitrates N_CH CPU channels onto one addr_ok/data_ok bus port,
// keeping per-channel stall/flush behaviour and draining flushed transactions.
module ahb_bus_arb_if
  import ahb_bus_arb_if_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int ARB_RR = 1,
  parameter int REMAP = 1,
  localparam int BW = DW / 8,
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       stall_i,
  input  logic             flush_i,
  input  logic [N_CH-1:0]  cpu_ce_i,
  input  logic [N_CH-1:0]  cpu_we_i,
  input  logic [N_CH*AW-1:0] cpu_addr_i,
  input  logic [N_CH*DW-1:0] cpu_data_i,
  input  logic [N_CH*BW-1:0] cpu_sel_i,
  output logic [N_CH*DW-1:0] cpu_data_o,
  output logic [N_CH-1:0]  stallreq_o,
  input  logic             addr_ok,
  input  logic             data_ok,
  input  logic [DW-1:0]    dout,
  output logic             req,
  output logic [AW-1:0]    addr,
  output logic [DW-1:0]    din,
  output logic             wr,
  output logic [BW-1:0]    ben,
  output logic [IW-1:0]    gnt_o
);
  bus_st_e bus_q;
  logic [IW-1:0] own_q, ptr_q, win_idx;
  logic own_we_q, any_elig, issue, done;
  logic [N_CH-1:0] elig, win_oh;
  logic [AW-1:0] win_addr, bus_addr_d;

  ahb_rr_arbiter #(.N_CH(N_CH), .ARB_RR(ARB_RR), .IW(IW)) u_arb (
    .req_i(elig),
    .ptr_i(ptr_q),
    .gnt_o(win_oh),
    .idx_o(win_idx),
    .any_o(any_elig)
  );

  assign issue = bus_q == IDLE && any_elig && addr_ok;
  assign done = bus_q == BUSY && data_ok;
  assign win_addr = cpu_addr_i[int'(win_idx)*AW +: AW];
  assign bus_addr_d = REMAP != 0 ? {kseg_strip(win_addr[AW-1:AW-4]), win_addr[AW-5:0]} : win_addr;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus_q <= IDLE;
      own_q <= '0;
      own_we_q <= 1'b0;
      ptr_q <= '0;
      req <= 1'b0;
      addr <= '0;
      din <= '0;
      wr <= 1'b0;
      ben <= '0;
      gnt_o <= '0;
    end else begin
      req <= issue;
      addr <= issue ? bus_addr_d : '0;
      din <= issue ? cpu_data_i[int'(win_idx)*DW +: DW] : '0;
      wr <= issue && cpu_we_i[win_idx];
      ben <= issue ? cpu_sel_i[int'(win_idx)*BW +: BW] : '0;
      if (issue) begin
        gnt_o <= win_idx;
        own_q <= win_idx;
        own_we_q <= cpu_we_i[win_idx];
        ptr_q <= ARB_RR != 0 ? win_idx : ptr_q;
      end
      // data_ok beats a same-cycle flush; a later flush forces a drain
      bus_q <= issue ? BUSY :
               bus_q == BUSY ? (data_ok ? IDLE : flush_i ? DRAIN : BUSY) :
               bus_q == DRAIN && data_ok ? IDLE : bus_q;
    end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ch_st_e ch_q;
    logic [DW-1:0] rd_buf_q;
    logic own_done;
    assign own_done = done && own_q == IW'(g);
    assign elig[g] = cpu_ce_i[g] && ch_q == CH_IDLE && !flush_i;
    assign stallreq_o[g] = !rst && cpu_ce_i[g] && !flush_i && ch_q != CH_HOLD && !own_done;
    assign cpu_data_o[g*DW +: DW] = own_done && !own_we_q ? dout :
                                    ch_q == CH_HOLD ? rd_buf_q : '0;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        ch_q <= CH_IDLE;
        rd_buf_q <= '0;
      end else if (flush_i) begin
        ch_q <= CH_IDLE;
        rd_buf_q <= '0;
      end else if (issue && win_oh[g]) begin
        ch_q <= CH_WAIT;
      end else if (own_done) begin
        ch_q <= stall_i != '0 ? CH_HOLD : CH_IDLE;
        rd_buf_q <= stall_i != '0 && !own_we_q ? dout : '0;
      end else if (ch_q == CH_HOLD && stall_i == '0) begin
        ch_q <= CH_IDLE;
      end
  end
endmodule

// File: tb/tb_ahb_bus_arb_if.sv
// tb_ahb_bus_arb_if: directed stimulus with a scoreboard; a negedge monitor checks every bus
// issue and every data_ok completion against queued expectations.
module tb_ahb_bus_arb_if;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] stall;
  logic flush, addr_ok, data_ok;
  logic [1:0] ce, we;
  logic [63:0] addr_in, data_in;
  logic [7:0] sel_in;
  logic [31:0] dout;
  logic [63:0] cpu_data_o, fp_data_o;
  logic [1:0] stallreq_o, fp_stallreq;
  logic req, wr, gnt, fp_req, fp_wr, fp_gnt;
  logic [31:0] addr, din, fp_addr, fp_din;
  logic [3:0] ben, fp_ben;

  typedef struct packed {logic [31:0] addr; logic [31:0] din; logic wr; logic [3:0] ben; logic gnt;} bus_t;
  typedef struct packed {logic ch; logic [31:0] data; logic stall;} cpl_t;
  bus_t exp_bus[$];
  cpl_t exp_cpl[$];
  bus_t eb;
  cpl_t ec;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  ahb_bus_arb_if #(.N_CH(2), .DW(32), .AW(32), .ARB_RR(1), .REMAP(1)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .cpu_ce_i(ce), .cpu_we_i(we), .cpu_addr_i(addr_in), .cpu_data_i(data_in), .cpu_sel_i(sel_in),
    .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o),
    .addr_ok(addr_ok), .data_ok(data_ok), .dout(dout),
    .req(req), .addr(addr), .din(din), .wr(wr), .ben(ben), .gnt_o(gnt)
  );

  ahb_bus_arb_if #(.N_CH(2), .DW(32), .AW(32), .ARB_RR(0), .REMAP(1)) dut_fp (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .cpu_ce_i(ce), .cpu_we_i(we), .cpu_addr_i(addr_in), .cpu_data_i(data_in), .cpu_sel_i(sel_in),
    .cpu_data_o(fp_data_o), .stallreq_o(fp_stallreq),
    .addr_ok(addr_ok), .data_ok(data_ok), .dout(dout),
    .req(fp_req), .addr(fp_addr), .din(fp_din), .wr(fp_wr), .ben(fp_ben), .gnt_o(fp_gnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (req) begin
      if (exp_bus.size() == 0) chk("unexpected_req", 32'(req), 32'd0);
      else begin
        eb = exp_bus.pop_front();
        chk("bus_addr", addr, eb.addr);
        chk("bus_din", din, eb.din);
        chk("bus_wr", 32'(wr), 32'(eb.wr));
        chk("bus_ben", 32'(ben), 32'(eb.ben));
        chk("bus_gnt", 32'(gnt), 32'(eb.gnt));
      end
    end
    if (data_ok) begin
      if (exp_cpl.size() == 0) chk("unexpected_data_ok", 32'(data_ok), 32'd0);
      else begin
        ec = exp_cpl.pop_front();
        chk("cpl_data", ec.ch ? cpu_data_o[63:32] : cpu_data_o[31:0], ec.data);
        chk("cpl_stallreq", 32'(stallreq_o[ec.ch]), 32'(ec.stall));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    stall = '0; flush = 0; addr_ok = 0; data_ok = 0; dout = '0;
    ce = 2'b01; we = '0; addr_in = '0; data_in = '0; sel_in = 8'hFF;
    #12;
    chk("rst_req", 32'(req), 0);
    chk("rst_addr", addr, 0);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_ben", 32'(ben), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_stallreq", 32'(stallreq_o), 0);
    chk("rst_cpu_data_lo", cpu_data_o[31:0], 0);
    ce = '0;
    @(posedge clk);
    #1 rst = 0;
    // single read on ch0 with kseg1 remap
    tick();
    ce = 2'b01; addr_in[31:0] = 32'hBFC00000; addr_ok = 1;
    exp_bus.push_back('{32'h1FC00000, 32'h0, 1'b0, 4'hF, 1'b0});
    #1 chk("rd_stall_pending", 32'(stallreq_o[0]), 1);
    tick();
    addr_ok = 0;
    #1 chk("rd_stall_busy", 32'(stallreq_o[0]), 1);
    tick();
    #1 chk("rd_req_one_cycle", 32'(req), 0);
    tick();
    tick();
    data_ok = 1; dout = 32'h12345678;
    exp_cpl.push_back('{1'b0, 32'h12345678, 1'b0});
    tick();
    data_ok = 0; dout = '0; ce = '0;
    // write on ch0, kseg0 remap
    ce = 2'b01; we = 2'b01; sel_in[3:0] = 4'b0011; addr_in[31:0] = 32'h80001000; data_in[31:0] = 32'h0000AABB; addr_ok = 1;
    exp_bus.push_back('{32'h00001000, 32'h0000AABB, 1'b1, 4'b0011, 1'b0});
    tick();
    addr_ok = 0;
    tick();
    data_ok = 1; dout = 32'hDEADBEEF;
    exp_cpl.push_back('{1'b0, 32'h0, 1'b0});
    tick();
    data_ok = 0; ce = '0; we = '0; sel_in[3:0] = 4'hF; data_in[31:0] = '0;
    // ch1 read completes under stall and must be held
    ce = 2'b10; addr_in[63:32] = 32'h00002000; addr_ok = 1;
    exp_bus.push_back('{32'h00002000, 32'h0, 1'b0, 4'hF, 1'b1});
    tick();
    addr_ok = 0;
    tick();
    data_ok = 1; dout = 32'hCAFEF00D; stall = 6'b000011;
    exp_cpl.push_back('{1'b1, 32'hCAFEF00D, 1'b0});
    tick();
    data_ok = 0; dout = '0; addr_ok = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_data", cpu_data_o[63:32], 32'hCAFEF00D);
      chk("hold_stallreq", 32'(stallreq_o[1]), 0);
      tick();
    end
    stall = '0;
    exp_bus.push_back('{32'h00002000, 32'h0, 1'b0, 4'hF, 1'b1});
    #1 chk("hold_last_cycle", cpu_data_o[63:32], 32'hCAFEF00D);
    tick();
    #1 chk("unhold_stallreq", 32'(stallreq_o[1]), 1);
    chk("unhold_data", cpu_data_o[63:32], 0);
    tick();
    addr_ok = 0;
    tick();
    data_ok = 1; dout = 32'h11112222;
    exp_cpl.push_back('{1'b1, 32'h11112222, 1'b0});
    tick();
    data_ok = 0; ce = '0;
    // contention: round-robin alternates, fixed priority keeps ch0
    ce = 2'b11; addr_in = {32'h00000200, 32'h00000100}; addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_bus.push_back('{32'h00000100, 32'h0, 1'b0, 4'hF, 1'b0});
      else exp_bus.push_back('{32'h00000200, 32'h0, 1'b0, 4'hF, 1'b1});
      exp_cpl.push_back('{1'(k % 2), 32'hA0 + 32'(k), 1'b0});
      tick();
      data_ok = 1; dout = 32'hA0 + 32'(k);
      #1 chk("fp_gnt", 32'(fp_gnt), 0);
      chk("fp_req", 32'(fp_req), 1);
      chk("fp_ch1_stalled", 32'(fp_stallreq[1]), 1);
      tick();
      data_ok = 0;
    end
    ce = '0; addr_ok = 0;
    // flush after issue drains the transaction
    ce = 2'b01; addr_in[31:0] = 32'h90000040; addr_ok = 1;
    exp_bus.push_back('{32'h10000040, 32'h0, 1'b0, 4'hF, 1'b0});
    tick();
    flush = 1; addr_ok = 0;
    #1 chk("flush_stallreq", 32'(stallreq_o[0]), 0);
    tick();
    flush = 0; addr_ok = 1;
    #1 chk("drain_stallreq", 32'(stallreq_o[0]), 1);
    tick();
    tick();
    data_ok = 1; dout = 32'hBADBAD00;
    exp_cpl.push_back('{1'b0, 32'h0, 1'b1});
    tick();
    data_ok = 0;
    exp_bus.push_back('{32'h10000040, 32'h0, 1'b0, 4'hF, 1'b0});
    tick();
    addr_ok = 0; data_ok = 1; dout = 32'h55AA55AA;
    exp_cpl.push_back('{1'b0, 32'h55AA55AA, 1'b0});
    tick();
    data_ok = 0; ce = '0;
    // async reset while busy
    ce = 2'b10; addr_in[63:32] = 32'h00000300; addr_ok = 1;
    exp_bus.push_back('{32'h00000300, 32'h0, 1'b0, 4'hF, 1'b1});
    tick();
    addr_ok = 0;
    @(negedge clk);
    #1 rst = 1;
    #1 chk("arst_req", 32'(req), 0);
    chk("arst_addr", addr, 0);
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_stallreq", 32'(stallreq_o), 0);
    chk("arst_cpu_data_hi", cpu_data_o[63:32], 0);
    tick();
    rst = 0; ce = '0;
    tick();
    data_ok = 1; dout = 32'h77777777;
    exp_cpl.push_back('{1'b1, 32'h0, 1'b0});
    #1 chk("post_rst_data_lo", cpu_data_o[31:0], 0);
    tick();
    data_ok = 0;
    tick();
    tick();
    chk("bus_queue_drained", 32'(exp_bus.size()), 0);
    chk("cpl_queue_drained", 32'(exp_cpl.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_bus_arb_if.md
Name: ahb_bus_arb_if

Overview:
- Multi-channel successor of the CPU-to-AHB bridge. Arbitrates N_CH CPU-side request channels (ch0 = data, ch1 = instruction fetch by default) onto one AHB-style addr_ok/data_ok bus port.
- Keeps the pipeline-stall and flush contract per channel, adds kseg address remap as an option, and handles a flush that arrives after a request has already been issued on the bus.
- Sits between the MIPS core (IF/MEM stages) and the bus wrapper, replacing per-stage bridge instances.

Parameters:
- N_CH, 2, number of CPU channels (1..4); index 0 has highest fixed priority.
- DW, 32, data width; byte-enable width BW = DW/8.
- AW, 32, address width.
- ARB_RR, 1, 1 = round-robin arbitration, 0 = fixed priority.
- REMAP, 1, 1 = strip kseg0/kseg1 (0x8/0x9/0xA/0xB -> 0x0/0x1 in addr[AW-1:AW-4]), 0 = pass-through.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- stall_i  in  6  pipeline stall vector from ctrl.
- flush_i  in  1  pipeline flush from ctrl.
- cpu_ce_i  in  N_CH  per-channel request.
- cpu_we_i  in  N_CH  per-channel write enable.
- cpu_addr_i  in  N_CH*AW  packed addresses, ch0 in the LSBs.
- cpu_data_i  in  N_CH*DW  packed write data.
- cpu_sel_i  in  N_CH*BW  packed byte enables.
- cpu_data_o  out  N_CH*DW  packed read data.
- stallreq_o  out  N_CH  per-channel stall request.
- addr_ok  in  1  bus accepts a request this cycle.
- data_ok  in  1  bus completes the outstanding request.
- dout  in  DW  bus read data.
- req  out  1  bus request valid.
- addr  out  AW  bus address.
- din  out  DW  bus write data.
- wr  out  1  bus write.
- ben  out  BW  bus byte enables.
- gnt_o  out  clog2(N_CH) (min 1)  index of the channel owning the bus; debug only.

Behaviour:
- Reset: req=0, addr=0, din=0, wr=0, ben=0, gnt_o=0, all rd_buf=0, bus FSM = IDLE, every channel = CH_IDLE, RR pointer = 0. While rst is high, stallreq_o=0 and cpu_data_o=0.
- Bus FSM states: IDLE, BUSY, DRAIN. One outstanding transaction at a time.
- IDLE:
  - Eligible channels: cpu_ce_i=1, channel in CH_IDLE, flush_i=0.
  - Winner selection: fixed priority picks the lowest eligible index. Round-robin searches from ptr+1 and wraps modulo N_CH.
  - If any channel is eligible and addr_ok=1, register {remapped addr, data, we, sel} onto the bus with req=1 for exactly one cycle, set gnt_o, and go to BUSY. Round-robin updates ptr to the winner.
  - If addr_ok=0, stay in IDLE and re-arbitrate every cycle.
- BUSY:
  - The cycle after issue, clear req/addr/din/wr/ben to 0.
  - On data_ok=1 with no flush seen: go to IDLE.
  - On flush_i=1 before data_ok: go to DRAIN. The flushed transaction's data is discarded.
  - If data_ok and flush_i are both high in the same cycle, data_ok wins: data is delivered, no DRAIN.
- DRAIN: wait for data_ok, drop dout, go to IDLE. No new issue is made while in DRAIN.
- Per-channel state: CH_IDLE, CH_WAIT, CH_HOLD.
  - stallreq_o[i] = 1 when cpu_ce_i[i]=1 and flush_i=0 and the channel is in CH_IDLE or CH_WAIT, except in the data_ok cycle of its own transaction. That covers both pending-not-granted and issued-not-complete.
  - Granted channel enters CH_WAIT.
  - Completion cycle (data_ok, owner i, not draining): stallreq_o[i]=0. cpu_data_o[i] = dout combinationally for reads, 0 for writes.
  - If stall_i != 0 at that edge: latch the read data (or 0 for a write) into rd_buf[i] and enter CH_HOLD. Otherwise return to CH_IDLE.
  - CH_HOLD: cpu_data_o[i] = rd_buf[i], stallreq_o[i]=0, new requests from this channel are ignored. Leave for CH_IDLE when stall_i == 0.
  - flush_i forces every channel from CH_WAIT/CH_HOLD to CH_IDLE and clears rd_buf.
- Outside the above cases, cpu_data_o[i] = 0.
- Remap applies only to the top 4 address bits. All other bits pass unchanged.
- Reset asserted mid-transaction returns everything to the reset state immediately. An outstanding bus data_ok after reset is ignored because the FSM is in IDLE with no owner.

Decomposition:
- Shared package (the existing defines header): bus FSM and channel state encodings, RstEnable/Stop/NoStop/ZeroWord constants, kseg remap constants.
- One sub-module, ahb_rr_arbiter: N_CH request vector + pointer -> one-hot grant and index, fixed/RR mode by parameter.

Test Plan:
- Single read, N_CH=2: ch0 ce, addr 0xBFC00000, addr_ok=1, data_ok 3 cycles later with dout 0x12345678 -> one-cycle req with addr 0x1FC00000. stallreq_o[0] is high until the data_ok cycle, where cpu_data_o[0]=0x12345678.
- Contention, ARB_RR=1: ch0 and ch1 held, every transaction completes in 2 cycles -> grants alternate 0,1,0,1. With ARB_RR=0, ch0 always wins and ch1 stays stalled.
- Stall hold: data_ok with stall_i=6'b000011, dout 0xCAFEF00D -> cpu_data_o[1]=0xCAFEF00D held for every stalled cycle with stallreq_o[1]=0. No re-issue until stall_i=0.
- Flush mid-flight: flush_i pulses 1 cycle after issue, data_ok 4 cycles later -> FSM goes through DRAIN, the data is not delivered, no new req until after data_ok, then a new request issues normally.
- Write: ch0 we=1, sel 4'b0011, addr 0x80001000, data 0xAABB -> wr=1, ben=0011, addr 0x00001000, din 0xAABB, and cpu_data_o[0]=0 at completion.
- Async reset asserted while in BUSY with req pending -> all outputs 0 in the same cycle without waiting for a clk edge, and a later data_ok produces no completion.
